// File: rtl/fwd_pkg.sv
// Shared definitions for the forwarding / load-use hazard unit: operand-mux select codes
// and the default-width destination-tracking slot record.
package fwd_pkg;

    localparam int unsigned REG_AW_DEFAULT = 5;
    localparam int unsigned FWD_W          = 2;

    localparam logic [FWD_W-1:0] FWD_RF     = 2'd0;
    localparam logic [FWD_W-1:0] FWD_EXMEM  = 2'd1;
    localparam logic [FWD_W-1:0] FWD_MEMWB  = 2'd2;
    localparam logic [FWD_W-1:0] FWD_POSTWB = 2'd3;

    typedef struct packed {
        logic                      valid;
        logic [REG_AW_DEFAULT-1:0] dst;
        logic                      regwrite;
        logic                      memread;
    } slot_t;

endpackage

// File: rtl/dst_track_slot.sv
// One stage of the destination-register shadow pipeline; a bubble clears the slot,
// otherwise load captures the upstream record.
module dst_track_slot #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         bubble,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (bubble) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/forward_hazard_unit.sv
// ALU operand forwarding selects and load-use stall for the 5-stage pipeline.
// Define FWD_POSTWB_EN to track the post-WB slot and forward WB-slot producers with code 3.
module forward_hazard_unit
    import fwd_pkg::*;
#(
    parameter int unsigned REG_AW = REG_AW_DEFAULT
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              IdValid,
    input  logic [REG_AW-1:0] IdRs,
    input  logic [REG_AW-1:0] IdRt,
    input  logic              IdUsesRs,
    input  logic              IdUsesRt,
    input  logic [REG_AW-1:0] IdDst,
    input  logic              IdRegWrite,
    input  logic              IdMemRead,
    input  logic              Flush,
    output logic              Stall,
    output logic [FWD_W-1:0]  FwdA,
    output logic [FWD_W-1:0]  FwdB
);

    localparam int unsigned SLOT_W = REG_AW + 3;

    // Same layout as fwd_pkg::slot_t, sized by this instance's register width.
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] dst;
        logic              regwrite;
        logic              memread;
    } slot_rec_t;

    slot_rec_t        ex_d;
    slot_rec_t        ex_q;
    slot_rec_t        mem_q;
    slot_rec_t        wb_q;
    logic             id_live_c;
    logic [FWD_W-1:0] fwd_a_c;
    logic [FWD_W-1:0] fwd_b_c;
    logic             unused_slot_bits_c;

    function automatic logic hit(input slot_rec_t s, input logic [REG_AW-1:0] r);
        return s.valid & s.regwrite & (s.dst != '0) & (s.dst == r);
    endfunction

    // Newest producer wins: EX before MEM before WB.
    function automatic logic [FWD_W-1:0] sel(input logic uses, input logic [REG_AW-1:0] r,
                                            input slot_rec_t ex, input slot_rec_t mem,
                                            input slot_rec_t wb);
        logic [FWD_W-1:0] code;
        code = FWD_RF;
        if (uses) begin
            if (hit(ex, r)) begin
                code = FWD_EXMEM;
            end else if (hit(mem, r)) begin
                code = FWD_MEMWB;
`ifdef FWD_POSTWB_EN
            end else if (hit(wb, r)) begin
                code = FWD_POSTWB;
`endif
            end
        end
        return code;
    endfunction

    assign id_live_c = IdValid & ~Flush;

    assign Stall = id_live_c & ex_q.valid & ex_q.memread & ex_q.regwrite & (ex_q.dst != '0)
                 & ((IdUsesRs & (IdRs == ex_q.dst)) | (IdUsesRt & (IdRt == ex_q.dst)));

    always_comb begin
        ex_d          = '0;
        ex_d.valid    = id_live_c;
        ex_d.dst      = IdDst;
        ex_d.regwrite = IdRegWrite;
        ex_d.memread  = IdMemRead;
    end

    always_comb begin
        fwd_a_c = sel(IdUsesRs, IdRs, ex_q, mem_q, wb_q);
        fwd_b_c = sel(IdUsesRt, IdRt, ex_q, mem_q, wb_q);
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            FwdA <= FWD_RF;
            FwdB <= FWD_RF;
        end else if (Stall | ~id_live_c) begin
            FwdA <= FWD_RF;
            FwdB <= FWD_RF;
        end else begin
            FwdA <= fwd_a_c;
            FwdB <= fwd_b_c;
        end
    end

    dst_track_slot #(.W(SLOT_W)) u_ex (
        .clk(Clk), .rst(Rst), .load(1'b1), .bubble(Stall), .d(ex_d), .q(ex_q)
    );

    dst_track_slot #(.W(SLOT_W)) u_mem (
        .clk(Clk), .rst(Rst), .load(1'b1), .bubble(1'b0), .d(ex_q), .q(mem_q)
    );

    dst_track_slot #(.W(SLOT_W)) u_wb (
        .clk(Clk), .rst(Rst), .load(1'b1), .bubble(1'b0), .d(mem_q), .q(wb_q)
    );

`ifdef FWD_POSTWB_EN
    slot_rec_t pwb_q;

    // Post-WB occupancy mirrors the holding register; no select reads it.
    dst_track_slot #(.W(SLOT_W)) u_pwb (
        .clk(Clk), .rst(Rst), .load(1'b1), .bubble(1'b0), .d(wb_q), .q(pwb_q)
    );

    assign unused_slot_bits_c = ^{mem_q.memread, wb_q.memread, pwb_q};
`else
    assign unused_slot_bits_c = ^{mem_q.memread, wb_q};
`endif

endmodule
